// File: rtl/skein_pkg.sv
// Shared Threefish-1024 constants: rotation table, word permutation and the
// round-engine FSM encoding.
package skein_pkg;

    localparam int WORD_W  = 64;
    localparam int N_WORDS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Row d is used for round numbers with round mod 8 == d; column j is the pair index.
    localparam logic [5:0] ROT_TABLE [8][8] = '{
        '{6'd24, 6'd13, 6'd8,  6'd47, 6'd8,  6'd17, 6'd22, 6'd37},
        '{6'd38, 6'd19, 6'd10, 6'd55, 6'd49, 6'd18, 6'd23, 6'd52},
        '{6'd33, 6'd4,  6'd51, 6'd13, 6'd34, 6'd41, 6'd59, 6'd17},
        '{6'd5,  6'd20, 6'd48, 6'd41, 6'd47, 6'd28, 6'd16, 6'd25},
        '{6'd41, 6'd9,  6'd37, 6'd31, 6'd12, 6'd47, 6'd44, 6'd30},
        '{6'd16, 6'd34, 6'd56, 6'd51, 6'd4,  6'd53, 6'd42, 6'd41},
        '{6'd31, 6'd44, 6'd47, 6'd46, 6'd19, 6'd42, 6'd44, 6'd25},
        '{6'd9,  6'd48, 6'd35, 6'd52, 6'd23, 6'd31, 6'd37, 6'd20}
    };

    // Output word i is taken from MIX output word PERM[i].
    localparam logic [3:0] PERM [16] = '{
        4'd0,  4'd9,  4'd2,  4'd13, 4'd6,  4'd11, 4'd4,  4'd15,
        4'd10, 4'd7,  4'd12, 4'd3,  4'd14, 4'd5,  4'd8,  4'd1
    };

endpackage

// File: rtl/mix64.sv
// Threefish MIX on one 64-bit word pair: add, rotate-left, xor.
module mix64 (
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [5:0]  r,
    output logic [63:0] y0,
    output logic [63:0] y1
);

    logic [63:0] x1_rot;

    // A zero rotation would shift right by 64 and contribute nothing, which is still correct.
    assign x1_rot = (x1 << r) | (x1 >> (7'd64 - {1'b0, r}));
    assign y0     = x0 + x1;
    assign y1     = x1_rot ^ y0;

endmodule

// File: rtl/mix_round_engine.sv
// One Threefish-1024 MIX round, evaluated one word pair per cycle and
// committed to state_o as a single permuted 1024-bit update.
module mix_round_engine #(
    parameter int WORD_W  = skein_pkg::WORD_W,
    parameter int N_WORDS = skein_pkg::N_WORDS
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    // start_i is a request sampled only while busy_o is low (busy_o acts as not-ready);
    // done_o is a one-cycle valid for the newly committed state_o, which then holds.
    input  logic                      start_i,
    input  logic [6:0]                round_i,
    output logic [3:0]                word_o,
    input  logic [WORD_W-1:0]         x0_i,
    input  logic [WORD_W-1:0]         x1_i,
    output logic [WORD_W*N_WORDS-1:0] state_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      dbg_state_o
);

    import skein_pkg::state_e;
    import skein_pkg::IDLE;
    import skein_pkg::RUN;
    import skein_pkg::ROT_TABLE;
    import skein_pkg::PERM;

    state_e              state_q;
    state_e              state_d;
    logic [2:0]          pair_q;
    logic [2:0]          row_q;
    logic [WORD_W-1:0]   stage_q [14];
    logic [WORD_W-1:0]   f_all   [16];
    logic [WORD_W*N_WORDS-1:0] perm_vec;
    logic [WORD_W-1:0]   y0;
    logic [WORD_W-1:0]   y1;
    logic [5:0]          rot;
    logic                accept;
    logic                commit;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (pair_q == 3'd7) begin
                    state_d = IDLE;
                    commit  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rot = ROT_TABLE[row_q][pair_q];

    mix64 u_mix (
        .x0 (x0_i),
        .x1 (x1_i),
        .r  (rot),
        .y0 (y0),
        .y1 (y1)
    );

    // The last pair is never staged: the commit edge takes it straight from the MIX output.
    always_comb begin
        for (int i = 0; i < 14; i++) begin
            f_all[i] = stage_q[i];
        end
        f_all[14] = y0;
        f_all[15] = y1;
        perm_vec  = '0;
        for (int i = 0; i < 16; i++) begin
            perm_vec[i*WORD_W +: WORD_W] = f_all[PERM[i]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pair_q  <= 3'd0;
            row_q   <= 3'd0;
            state_o <= '0;
            done_o  <= 1'b0;
            for (int i = 0; i < 14; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_o  <= commit;
            if (accept) begin
                row_q  <= round_i[2:0];
                pair_q <= 3'd0;
            end else if (state_q == RUN) begin
                pair_q <= pair_q + 3'd1;
                if (pair_q != 3'd7) begin
                    stage_q[{pair_q, 1'b0}] <= y0;
                    stage_q[{pair_q, 1'b1}] <= y1;
                end
            end
            if (commit) begin
                state_o <= perm_vec;
            end
        end
    end

    // pair_q wraps back to 0 on commit, so word_o rests at 0 while idle.
    assign word_o      = {pair_q, 1'b0};
    assign busy_o      = (state_q == RUN);
    assign dbg_state_o = logic'(state_q);

endmodule
